// File: rtl/tx_interp_pkg.sv
// tx_interp_pkg: constants and types shared across the Tx interpolation chain
package tx_interp_pkg;
  localparam int IN_W       = 20;
  localparam int OUT_W      = 11;
  localparam int SHIFT      = 9;
  localparam int NUM_PHASES = 4;
  localparam int ROUND_BIAS = 1 << (SHIFT - 1);
  typedef logic [1:0] phase_t;
  typedef enum logic {ST_IDLE, ST_EMIT} state_t;
endpackage

// File: rtl/interp_round_sat.sv
// interp_round_sat: round half-up, normalise by 2^SHIFT and saturate to OUT_W
module interp_round_sat #(
  parameter int IN_W  = tx_interp_pkg::IN_W,
  parameter int OUT_W = tx_interp_pkg::OUT_W,
  parameter int SHIFT = tx_interp_pkg::SHIFT
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    sat_o
);
  localparam int SW = IN_W + 1 - SHIFT;
  logic signed [IN_W:0]     biased;
  logic signed [SW-1:0]     shifted;
  logic        [SW-OUT_W:0] top;
  assign biased  = {x_i[IN_W-1], x_i} + (IN_W+1)'(1 << (SHIFT - 1));
  assign shifted = SW'(biased >>> SHIFT);
  assign top     = shifted[SW-1:OUT_W-1];
  assign sat_o   = (top != '0) && (top != '1);
  assign y_o     = sat_o ? {top[SW-OUT_W], {(OUT_W-1){~top[SW-OUT_W]}}} : shifted[OUT_W-1:0];
endmodule

// File: rtl/interp_polyphase_commutator.sv
// interp_polyphase_commutator: double-buffer four branch outputs and serialise them E0..E3
module interp_polyphase_commutator #(
  parameter int IN_W  = tx_interp_pkg::IN_W,
  parameter int OUT_W = tx_interp_pkg::OUT_W,
  parameter int SHIFT = tx_interp_pkg::SHIFT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [IN_W-1:0]         e0,
  input  logic [IN_W-1:0]         e1,
  input  logic [IN_W-1:0]         e2,
  input  logic [IN_W-1:0]         e3,
  input  logic                    ovr_clr,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sample,
  output logic [1:0]              out_phase,
  output logic                    sat,
  output logic                    overrun
);
  import tx_interp_pkg::*;
  typedef logic [NUM_PHASES-1:0][IN_W-1:0] bank_t;
  state_t st_q, st_d;
  phase_t phase_q, phase_d;
  bank_t act_q, act_d, pend_q, pend_d, in_set;
  logic pfull_q, pfull_d, ovr_q, ovr_d;
  logic vld_q, vld_d, sat_q, sat_d;
  logic signed [OUT_W-1:0] smp_q, smp_d, rs_y;
  phase_t oph_q, oph_d;
  logic rs_sat, emit, last;
  assign in_set = {e3, e2, e1, e0};
  assign emit   = st_q == ST_EMIT;
  assign last   = phase_q == phase_t'(NUM_PHASES - 1);
  interp_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs (
    .x_i  (act_q[phase_q]),
    .y_o  (rs_y),
    .sat_o(rs_sat)
  );
  // next state: start/continue emission, refill active from inputs or pending, park or drop jitter sets
  always_comb begin
    st_d    = st_q;
    phase_d = emit ? phase_q + 2'd1 : 2'd0;
    act_d   = act_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    ovr_d   = ovr_q & ~ovr_clr;
    vld_d   = emit;
    smp_d   = emit ? rs_y : '0;
    sat_d   = emit & rs_sat;
    oph_d   = emit ? phase_q : 2'd0;
    if (!emit) begin
      if (in_valid) begin
        act_d = in_set;
        st_d  = ST_EMIT;
      end
    end else if (last) begin
      if (in_valid) act_d = in_set;
      else if (pfull_q) begin
        act_d   = pend_q;
        pfull_d = 1'b0;
      end else st_d = ST_IDLE;
    end else if (in_valid) begin
      if (!pfull_q) begin
        pend_d  = in_set;
        pfull_d = 1'b1;
      end else ovr_d = 1'b1;
    end
  end
  // state, banks and registered outputs; reset discards everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      phase_q <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pfull_q <= 1'b0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
      smp_q   <= '0;
      sat_q   <= 1'b0;
      oph_q   <= '0;
    end else begin
      st_q    <= st_d;
      phase_q <= phase_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      ovr_q   <= ovr_d;
      vld_q   <= vld_d;
      smp_q   <= smp_d;
      sat_q   <= sat_d;
      oph_q   <= oph_d;
    end
  end
  assign out_valid  = vld_q;
  assign out_sample = smp_q;
  assign out_phase  = oph_q;
  assign sat        = sat_q;
  assign overrun    = ovr_q;
endmodule
